lock_actuator_ctrl: RTL and testbench

LOCK_ACTUATOR_CTRL -- requirements
Module: lock_actuator_ctrl

---
 rtl/lock_actuator_ctrl.sv | 114 +++++++++++
 tb/tb_lock_actuator_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_actuator_ctrl.sv
// rtl/lock_actuator_ctrl.sv - code-verdict driven lock actuator with unlock window and failure lockout
module lock_actuator_ctrl #(
    parameter int UNLOCK_CYCLES  = 16,
    parameter int LOCKOUT_CYCLES = 64,
    parameter int MAX_FAILS      = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             verdict_valid,
    input  logic                             verdict_match,
    output logic                             verdict_ready,
    input  logic                             relock,
    output logic                             unlock,
    output logic                             lockout,
    output logic                             alarm,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

    localparam int FW   = $clog2(MAX_FAILS + 1);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [FW-1:0] FAIL_LAST    = FW'(MAX_FAILS - 1);
    localparam logic [FW-1:0] FAIL_MAX     = FW'(MAX_FAILS);
    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [TW-1:0]   timer, timer_next;
    logic [FW-1:0]   fail_next;
    logic            unlock_next, lockout_next, alarm_next;
    logic            accept;

    // Only a LOCKED, non-reset block takes verdicts; anything else is dropped.
    assign verdict_ready = (state == ST_LOCKED) && !rst;
    assign accept        = verdict_valid && verdict_ready;

    // State, timer and registered outputs; reset aborts any open window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOCKED;
            timer      <= '0;
            fail_count <= '0;
            unlock     <= 1'b0;
            lockout    <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            fail_count <= fail_next;
            unlock     <= unlock_next;
            lockout    <= lockout_next;
            alarm      <= alarm_next;
        end
    end

    // Next-state, timer and failure-count logic; outputs derive from the next state.
    always_comb begin
        state_next = state;
        timer_next = timer;
        fail_next  = fail_count;
        case (state)
            ST_LOCKED: begin
                timer_next = '0;
                if (accept) begin
                    if (verdict_match) begin
                        state_next = ST_UNLOCKED;
                        fail_next  = '0;
                        timer_next = UNLOCK_LOAD;
                    end else if (fail_count == FAIL_LAST) begin
                        state_next = ST_LOCKOUT;
                        fail_next  = FAIL_MAX;
                        timer_next = LOCKOUT_LOAD;
                    end else begin
                        fail_next  = fail_count + FW'(1);
                    end
                end
            end
            ST_UNLOCKED: begin
                // Timer value N means N open cycles remain including this one.
                if (relock || timer <= TW'(1)) begin
                    state_next = ST_LOCKED;
                    timer_next = '0;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            ST_LOCKOUT: begin
                if (timer <= TW'(1)) begin
                    state_next = ST_LOCKED;
                    timer_next = '0;
                    fail_next  = '0;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            default: begin
                state_next = ST_LOCKED;
                timer_next = '0;
                fail_next  = '0;
            end
        endcase
        unlock_next  = (state_next == ST_UNLOCKED);
        lockout_next = (state_next == ST_LOCKOUT);
        alarm_next   = (state_next == ST_LOCKOUT) && (state != ST_LOCKOUT);
    end

endmodule

// File: tb/tb_lock_actuator_ctrl.sv
// tb/tb_lock_actuator_ctrl.sv - directed self-checking bench for lock_actuator_ctrl
module tb_lock_actuator_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       verdict_valid = 1'b0;
    logic       verdict_match = 1'b0;
    logic       verdict_ready;
    logic       relock = 1'b0;
    logic       unlock;
    logic       lockout;
    logic       alarm;
    logic [1:0] fail_count;

    int checks = 0;
    int failures = 0;

    lock_actuator_ctrl #(
        .UNLOCK_CYCLES (16),
        .LOCKOUT_CYCLES(64),
        .MAX_FAILS     (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .verdict_valid(verdict_valid),
        .verdict_match(verdict_match),
        .verdict_ready(verdict_ready),
        .relock       (relock),
        .unlock       (unlock),
        .lockout      (lockout),
        .alarm        (alarm),
        .fail_count   (fail_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic m);
        verdict_valid = 1'b1;
        verdict_match = m;
        step();
        verdict_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        verdict_valid = 1'b1;
        verdict_match = 1'b1;
        step();
        step();
        checks++;
        if ({unlock, lockout, alarm, fail_count} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b%b%b fc=%0d want 000 fc=0", unlock, lockout, alarm, fail_count);
        end
        checks++;
        if (verdict_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b want 0", verdict_ready);
        end
        verdict_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (verdict_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b want 1", verdict_ready);
        end
    endtask

    task automatic test_unlock();
        int cnt = 0;
        int bad = 0;
        send(1'b1);
        while (unlock === 1'b1 && cnt < 40) begin
            if (verdict_ready !== 1'b0 || lockout !== 1'b0) bad++;
            cnt++;
            step();
        end
        checks++;
        if (cnt != 16) begin
            failures++;
            $display("FAIL unlock_length: got %0d want 16", cnt);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL unlock_ready_low: got %0d bad cycles want 0", bad);
        end
        checks++;
        if (verdict_ready !== 1'b1 || fail_count !== 2'd0) begin
            failures++;
            $display("FAIL unlock_exit: got ready=%b fc=%0d want ready=1 fc=0", verdict_ready, fail_count);
        end
    endtask

    task automatic test_lockout();
        int cnt = 0;
        int bad = 0;
        send(1'b0);
        checks++;
        if (fail_count !== 2'd1 || lockout !== 1'b0) begin
            failures++;
            $display("FAIL lockout_fc1: got fc=%0d lockout=%b want fc=1 lockout=0", fail_count, lockout);
        end
        send(1'b0);
        checks++;
        if (fail_count !== 2'd2 || lockout !== 1'b0) begin
            failures++;
            $display("FAIL lockout_fc2: got fc=%0d lockout=%b want fc=2 lockout=0", fail_count, lockout);
        end
        send(1'b0);
        checks++;
        if (fail_count !== 2'd3 || lockout !== 1'b1 || alarm !== 1'b1 || unlock !== 1'b0) begin
            failures++;
            $display("FAIL lockout_entry: got fc=%0d lockout=%b alarm=%b unlock=%b want 3 1 1 0",
                     fail_count, lockout, alarm, unlock);
        end
        verdict_valid = 1'b1;
        verdict_match = 1'b1;
        relock = 1'b1;
        while (lockout === 1'b1 && cnt < 100) begin
            if (verdict_ready !== 1'b0 || unlock !== 1'b0) bad++;
            if (cnt > 0 && alarm !== 1'b0) bad++;
            cnt++;
            step();
        end
        verdict_valid = 1'b0;
        relock = 1'b0;
        checks++;
        if (cnt != 64) begin
            failures++;
            $display("FAIL lockout_length: got %0d want 64", cnt);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL lockout_hold: got %0d bad cycles want 0", bad);
        end
        checks++;
        if (fail_count !== 2'd0 || verdict_ready !== 1'b1 || unlock !== 1'b0) begin
            failures++;
            $display("FAIL lockout_exit: got fc=%0d ready=%b unlock=%b want 0 1 0", fail_count, verdict_ready, unlock);
        end
    endtask

    task automatic test_mixed();
        send(1'b0);
        send(1'b0);
        checks++;
        if (fail_count !== 2'd2) begin
            failures++;
            $display("FAIL mixed_fc2: got %0d want 2", fail_count);
        end
        send(1'b1);
        checks++;
        if (fail_count !== 2'd0 || unlock !== 1'b1) begin
            failures++;
            $display("FAIL mixed_match: got fc=%0d unlock=%b want fc=0 unlock=1", fail_count, unlock);
        end
        relock = 1'b1;
        step();
        relock = 1'b0;
        send(1'b0);
        checks++;
        if (fail_count !== 2'd1 || lockout !== 1'b0 || alarm !== 1'b0) begin
            failures++;
            $display("FAIL mixed_after: got fc=%0d lockout=%b alarm=%b want 1 0 0", fail_count, lockout, alarm);
        end
    endtask

    task automatic test_relock();
        send(1'b1);
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (unlock !== 1'b1) begin
            failures++;
            $display("FAIL relock_pre: got unlock=%b want 1", unlock);
        end
        relock = 1'b1;
        step();
        relock = 1'b0;
        checks++;
        if (unlock !== 1'b0 || verdict_ready !== 1'b1) begin
            failures++;
            $display("FAIL relock_early: got unlock=%b ready=%b want 0 1", unlock, verdict_ready);
        end
        send(1'b1);
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (unlock !== 1'b1) begin
            failures++;
            $display("FAIL relock_last_cycle: got unlock=%b want 1", unlock);
        end
        relock = 1'b1;
        step();
        checks++;
        if (unlock !== 1'b0 || verdict_ready !== 1'b1) begin
            failures++;
            $display("FAIL relock_expiry: got unlock=%b ready=%b want 0 1", unlock, verdict_ready);
        end
        step();
        relock = 1'b0;
        checks++;
        if (unlock !== 1'b0 || lockout !== 1'b0 || verdict_ready !== 1'b1) begin
            failures++;
            $display("FAIL relock_locked_ignore: got unlock=%b lockout=%b ready=%b want 0 0 1",
                     unlock, lockout, verdict_ready);
        end
    endtask

    task automatic test_reset_lockout();
        send(1'b0);
        send(1'b0);
        send(1'b0);
        for (int i = 0; i < 29; i++) step();
        checks++;
        if (lockout !== 1'b1) begin
            failures++;
            $display("FAIL rst_lockout_pre: got lockout=%b want 1", lockout);
        end
        rst = 1'b1;
        verdict_valid = 1'b1;
        verdict_match = 1'b1;
        step();
        checks++;
        if (lockout !== 1'b0 || fail_count !== 2'd0 || verdict_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_lockout_abort: got lockout=%b fc=%0d ready=%b want 0 0 0",
                     lockout, fail_count, verdict_ready);
        end
        step();
        checks++;
        if (unlock !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_accept: got unlock=%b want 0", unlock);
        end
        verdict_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (verdict_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_release_ready: got %b want 1", verdict_ready);
        end
        step();
        checks++;
        if (unlock !== 1'b0 || lockout !== 1'b0 || fail_count !== 2'd0) begin
            failures++;
            $display("FAIL rst_release_idle: got unlock=%b lockout=%b fc=%0d want 0 0 0", unlock, lockout, fail_count);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_unlock();
        test_lockout();
        test_mixed();
        test_relock();
        test_reset_lockout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
